// File: rtl/shreg_pkg.sv
// Shared definitions for the universal shift register.
// Contents:
//   MODE_* : 3-bit operation codes carried on MODE.
//   state_t: command FSM encoding (IDLE, BUSY, DONE).
//   is_shift(): true for the modes that may be repeated by a START command.
package shreg_pkg;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_ROR  = 3'b101;
    localparam logic [2:0] MODE_ASR  = 3'b110;
    localparam logic [2:0] MODE_CLR  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Shift-class codes are the contiguous range SHL..ASR.
    function automatic logic is_shift(input logic [2:0] m);
        return (m >= MODE_SHL) && (m <= MODE_ASR);
    endfunction

endpackage

// File: rtl/shreg_step.sv
// One step of the universal shift register, purely combinational.
// Ports:
//   q      in  WIDTH  current register value
//   mode   in  3      operation code (MODE_*)
//   sil    in  1      serial bit entering at the MSB on SHR
//   sir    in  1      serial bit entering at the LSB on SHL
//   q_next out WIDTH  value after applying mode once
module shreg_step
    import shreg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  logic [2:0]       mode,
    input  logic             sil,
    input  logic             sir,
    output logic [WIDTH-1:0] q_next
);

    always_comb begin
        q_next = q;
        case (mode)
            MODE_HOLD: q_next = q;
            MODE_LOAD: q_next = q;  // parallel data is muxed in by the top
            MODE_SHL:  q_next = {q[WIDTH-2:0], sir};
            MODE_SHR:  q_next = {sil, q[WIDTH-1:1]};
            MODE_ROL:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
            MODE_ROR:  q_next = {q[0], q[WIDTH-1:1]};
            MODE_ASR:  q_next = {q[WIDTH-1], q[WIDTH-1:1]};
            MODE_CLR:  q_next = '0;
            default:   q_next = q;
        endcase
    end

endmodule

// File: rtl/shreg_univ.sv
// Universal shift register with a repeat-by-AMT command FSM.
// Ports:
//   CLK, RST         clock and synchronous active-high reset
//   EN               clock enable for every operation and FSM advance
//   MODE, D          operation code and parallel load data
//   SIL, SIR         serial inputs (MSB side on SHR, LSB side on SHL)
//   START, AMT       launch a multi-step shift/rotate of AMT steps
//   Q                register contents
//   SOUT_L, SOUT_R   Q[WIDTH-1] and Q[0]
//   BUSY, DONE       command status, decoded from the FSM state
module shreg_univ
    import shreg_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(WIDTH + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic [2:0]       MODE,
    input  logic [WIDTH-1:0] D,
    input  logic             SIL,
    input  logic             SIR,
    input  logic             START,
    input  logic [AW-1:0]    AMT,
    output logic [WIDTH-1:0] Q,
    output logic             SOUT_L,
    output logic             SOUT_R,
    output logic             BUSY,
    output logic             DONE
);

    logic [WIDTH-1:0] q_reg;
    logic [AW-1:0]    cnt_reg;
    logic [2:0]       cmd_mode_reg;
    state_t           state_reg;

    logic [2:0]       step_mode;
    logic [WIDTH-1:0] step_q;
    logic [WIDTH-1:0] single_q;

    // While a command runs the latched mode drives the step function,
    // so MODE changes on the bus cannot disturb it.
    assign step_mode = (state_reg == ST_BUSY) ? cmd_mode_reg : MODE;

    shreg_step #(.WIDTH(WIDTH)) u_step (
        .q      (q_reg),
        .mode   (step_mode),
        .sil    (SIL),
        .sir    (SIR),
        .q_next (step_q)
    );

    assign single_q = (MODE == MODE_LOAD) ? D : step_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            q_reg        <= '0;
            cnt_reg      <= '0;
            cmd_mode_reg <= MODE_HOLD;
            state_reg    <= ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (EN) begin
                        if (START && is_shift(MODE)) begin
                            cmd_mode_reg <= MODE;
                            if (AMT == '0) begin
                                state_reg <= ST_DONE;
                            end else begin
                                // First step happens on the START edge itself.
                                q_reg <= step_q;
                                if (AMT == AW'(1)) begin
                                    state_reg <= ST_DONE;
                                end else begin
                                    cnt_reg   <= AMT - AW'(1);
                                    state_reg <= ST_BUSY;
                                end
                            end
                        end else begin
                            q_reg <= single_q;
                        end
                    end
                end
                ST_BUSY: begin
                    if (EN) begin
                        q_reg   <= step_q;
                        cnt_reg <= cnt_reg - AW'(1);
                        if (cnt_reg == AW'(1)) begin
                            state_reg <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign Q      = q_reg;
    assign SOUT_L = q_reg[WIDTH-1];
    assign SOUT_R = q_reg[0];
    assign BUSY   = (state_reg == ST_BUSY);
    assign DONE   = (state_reg == ST_DONE);

endmodule

// File: tb/tb_shreg_univ.sv
// Self-checking bench for shreg_univ (WIDTH=8). Each cycle pushes the
// expected {BUSY, DONE, Q} onto a scoreboard queue as stimulus is driven,
// then pops and compares once the DUT has clocked.
module tb_shreg_univ;

    localparam int WIDTH = 8;
    localparam int AW    = $clog2(WIDTH + 1);

    logic             clk;
    logic             rst;
    logic             en;
    logic [2:0]       mode;
    logic [WIDTH-1:0] d;
    logic             sil;
    logic             sir;
    logic             start;
    logic [AW-1:0]    amt;
    logic [WIDTH-1:0] q;
    logic             sout_l;
    logic             sout_r;
    logic             busy;
    logic             done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [9:0] sb_q[$];   // {busy, done, q}

    shreg_univ #(.WIDTH(WIDTH)) dut (
        .CLK    (clk),
        .RST    (rst),
        .EN     (en),
        .MODE   (mode),
        .D      (d),
        .SIL    (sil),
        .SIR    (sir),
        .START  (start),
        .AMT    (amt),
        .Q      (q),
        .SOUT_L (sout_l),
        .SOUT_R (sout_r),
        .BUSY   (busy),
        .DONE   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // One clock cycle: drive, push expectation, clock, pop and compare.
    task automatic cyc(input string tag,
                       input logic rst_v, input logic en_v, input logic start_v,
                       input logic [2:0] mode_v, input logic [7:0] d_v,
                       input logic sil_v, input logic sir_v, input logic [3:0] amt_v,
                       input logic [7:0] eq, input logic eb, input logic ed);
        logic [9:0] e;
        rst   = rst_v;
        en    = en_v;
        start = start_v;
        mode  = mode_v;
        d     = d_v;
        sil   = sil_v;
        sir   = sir_v;
        amt   = amt_v;
        sb_q.push_back({eb, ed, eq});
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        $display("txn %-10s Q=%02h BUSY=%0b DONE=%0b", tag, q, busy, done);
        check_val({tag, "_q"},    32'(q),      32'(e[7:0]));
        check_val({tag, "_sl"},   32'(sout_l), 32'(e[7]));
        check_val({tag, "_sr"},   32'(sout_r), 32'(e[0]));
        check_val({tag, "_busy"}, 32'(busy),   32'(e[9]));
        check_val({tag, "_done"}, 32'(done),   32'(e[8]));
    endtask

    // Independent single-step reference, written with shift operators.
    function automatic logic [7:0] ref_step(input logic [7:0] cur, input logic [2:0] m,
                                            input logic [7:0] dv, input logic sl, input logic sr);
        logic [7:0] r;
        r = cur;
        case (m)
            3'd1: r = dv;
            3'd2: r = (cur << 1) | {7'd0, sr};
            3'd3: r = (cur >> 1) | {sl, 7'd0};
            3'd4: r = (cur << 1) | (cur >> 7);
            3'd5: r = (cur >> 1) | (cur << 7);
            3'd6: r = 8'($signed(cur) >>> 1);
            3'd7: r = 8'h00;
            default: r = cur;
        endcase
        return r;
    endfunction

    initial begin
        logic [7:0] mq;
        logic [2:0] rm;
        logic [7:0] rd;
        logic       rsl;
        logic       rsr;
        rst = 1'b1; en = 1'b0; start = 1'b0; mode = 3'd0;
        d = 8'h00; sil = 1'b0; sir = 1'b0; amt = '0;

        // Reset state
        cyc("rst0", 1, 0, 0, 3'd0, 8'h00, 0, 0, 4'd0, 8'h00, 0, 0);
        cyc("rst1", 1, 1, 0, 3'd1, 8'hFF, 0, 0, 4'd0, 8'h00, 0, 0);

        // Enable gating
        cyc("ld11",  0, 1, 0, 3'd1, 8'h11, 0, 0, 4'd0, 8'h11, 0, 0);
        cyc("en0",   0, 0, 0, 3'd1, 8'h3C, 0, 0, 4'd0, 8'h11, 0, 0);
        cyc("en1",   0, 1, 0, 3'd1, 8'h3C, 0, 0, 4'd0, 8'h3C, 0, 0);

        // Single steps
        cyc("ld81",  0, 1, 0, 3'd1, 8'h81, 0, 0, 4'd0, 8'h81, 0, 0);
        cyc("shl",   0, 1, 0, 3'd2, 8'h00, 0, 1, 4'd0, 8'h03, 0, 0);
        cyc("ld90",  0, 1, 0, 3'd1, 8'h90, 0, 0, 4'd0, 8'h90, 0, 0);
        cyc("asr",   0, 1, 0, 3'd6, 8'h00, 0, 0, 4'd0, 8'hC8, 0, 0);
        cyc("ld01",  0, 1, 0, 3'd1, 8'h01, 0, 0, 4'd0, 8'h01, 0, 0);
        cyc("ror",   0, 1, 0, 3'd5, 8'h00, 0, 0, 4'd0, 8'h80, 0, 0);

        // Multi-step ROL x3 from 81; MODE=CLR on the bus while busy must be ignored
        cyc("ld81b", 0, 1, 0, 3'd1, 8'h81, 0, 0, 4'd0, 8'h81, 0, 0);
        cyc("rol3_k",  0, 1, 1, 3'd4, 8'h00, 0, 0, 4'd3, 8'h03, 1, 0);
        cyc("rol3_b1", 0, 1, 1, 3'd7, 8'h00, 0, 0, 4'd0, 8'h06, 1, 0);
        cyc("rol3_b2", 0, 1, 0, 3'd7, 8'h00, 0, 0, 4'd0, 8'h0C, 0, 1);
        // In DONE all inputs are ignored, including a LOAD
        cyc("rol3_dn", 0, 1, 1, 3'd1, 8'hFF, 0, 0, 4'd2, 8'h0C, 0, 0);

        // Stall: SHR x4 from F0 with EN low for two cycles after step two
        cyc("ldF0",  0, 1, 0, 3'd1, 8'hF0, 0, 0, 4'd0, 8'hF0, 0, 0);
        cyc("shr_k",  0, 1, 1, 3'd3, 8'h00, 0, 0, 4'd4, 8'h78, 1, 0);
        cyc("shr_s2", 0, 1, 0, 3'd0, 8'h00, 0, 0, 4'd0, 8'h3C, 1, 0);
        cyc("stall1", 0, 0, 0, 3'd1, 8'hAA, 1, 0, 4'd0, 8'h3C, 1, 0);
        cyc("stall2", 0, 0, 1, 3'd7, 8'hAA, 1, 0, 4'd0, 8'h3C, 1, 0);
        cyc("shr_s3", 0, 1, 0, 3'd0, 8'h00, 0, 0, 4'd0, 8'h1E, 1, 0);
        cyc("shr_s4", 0, 1, 0, 3'd0, 8'h00, 0, 0, 4'd0, 8'h0F, 0, 1);
        cyc("shr_id", 0, 1, 0, 3'd0, 8'h00, 0, 0, 4'd0, 8'h0F, 0, 0);

        // AMT=0 and non-shift START
        cyc("amt0",   0, 1, 1, 3'd2, 8'h00, 0, 1, 4'd0, 8'h0F, 0, 1);
        cyc("amt0_id",0, 1, 0, 3'd0, 8'h00, 0, 0, 4'd0, 8'h0F, 0, 0);
        cyc("st_ld",  0, 1, 1, 3'd1, 8'h5A, 0, 0, 4'd3, 8'h5A, 0, 0);
        cyc("st_ld2", 0, 1, 0, 3'd0, 8'h00, 0, 0, 4'd0, 8'h5A, 0, 0);
        // AMT=1 completes at once
        cyc("amt1",   0, 1, 1, 3'd5, 8'h00, 0, 0, 4'd1, 8'h2D, 0, 1);
        cyc("amt1_id",0, 1, 0, 3'd0, 8'h00, 0, 0, 4'd0, 8'h2D, 0, 0);

        // Reset mid-command
        cyc("ldA5",   0, 1, 0, 3'd1, 8'hA5, 0, 0, 4'd0, 8'hA5, 0, 0);
        cyc("rol5_k", 0, 1, 1, 3'd4, 8'h00, 0, 0, 4'd5, 8'h4B, 1, 0);
        cyc("rol5_b", 0, 1, 0, 3'd0, 8'h00, 0, 0, 4'd0, 8'h96, 1, 0);
        cyc("rst_mid",1, 0, 0, 3'd0, 8'h00, 0, 0, 4'd0, 8'h00, 0, 0);
        cyc("rst_id", 0, 1, 0, 3'd0, 8'h00, 0, 0, 4'd0, 8'h00, 0, 0);

        // Random single steps against the reference model
        mq = 8'h00;
        for (int i = 0; i < 24; i++) begin
            rm  = 3'($urandom_range(0, 7));
            rd  = 8'($urandom);
            rsl = 1'($urandom);
            rsr = 1'($urandom);
            mq  = ref_step(mq, rm, rd, rsl, rsr);
            cyc($sformatf("rnd%0d", i), 0, 1, 0, rm, rd, rsl, rsr, 4'd0, mq, 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shreg_univ.md
# shreg_univ

Parametrised universal shift register, the successor to the single-bit enabled flip-flop. It provides a WIDTH-bit register with parallel load, clear, logical and arithmetic shifts, and rotates, plus serial in/out. It also supports a multi-step command: shift or rotate by AMT positions under a small FSM with BUSY/DONE status. It serves as the generic storage and serialisation element in datapaths and serial links.

## Interface
- WIDTH, 8: register width in bits, minimum 2.
- AW, $clog2(WIDTH+1): width of AMT, derived and not overridden.
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  reset, synchronous and active-high.
- EN  in  1  clock enable; gates every operation and FSM advance (RST excepted).
- MODE  in  3  operation code, defined under Operation.
- D  in  WIDTH  parallel load data.
- SIL  in  1  serial input entering at the MSB on SHR.
- SIR  in  1  serial input entering at the LSB on SHL.
- START  in  1  launch a multi-step command, sampled in IDLE with EN=1.
- AMT  in  AW  step count for START; used as given, not clamped.
- Q  out  WIDTH  register contents.
- SOUT_L  out  1  Q[WIDTH-1].
- SOUT_R  out  1  Q[0].
- BUSY  out  1  high while the FSM is in BUSY.
- DONE  out  1  one-cycle pulse when a multi-step command completes.

## Operation
- MODE codes:
  - 000 HOLD
  - 001 LOAD: Q<=D
  - 010 SHL: {Q[W-2:0],SIR}
  - 011 SHR: {SIL,Q[W-1:1]}
  - 100 ROL
  - 101 ROR
  - 110 ASR: {Q[W-1],Q[W-1:1]}
  - 111 CLR: Q<=0
- Shift-class modes are 010-110.
- FSM states: IDLE, BUSY, DONE.
- IDLE, EN=1, and either START=0 or MODE not shift-class: one step of MODE at the edge. FSM stays in IDLE and DONE does not pulse.
- IDLE, EN=1, START=1, MODE shift-class:
  - Latch MODE as the command mode.
  - AMT=0: Q unchanged; go to DONE.
  - AMT=1: perform one step at this edge; go to DONE.
  - AMT≥2: perform one step at this edge; load cnt<=AMT-1; go to BUSY.
- BUSY, EN=1: perform one step of the latched mode. cnt<=cnt-1; when cnt==1, go to DONE.
- BUSY, EN=0: stall. Q, cnt and state are held. MODE, START and AMT are ignored.
- In BUSY, SIL/SIR are sampled live at each step edge.
- DONE: lasts exactly one cycle, then IDLE. All inputs except RST are ignored, so back-to-back START is accepted only from IDLE.
- RST=1 at an edge: Q<=0, state<=IDLE, cnt<=0. RST has priority over EN and aborts any command mid-operation.
- Reset values: Q=0, SOUT_L=0, SOUT_R=0, BUSY=0, DONE=0.

## Timing
- All outputs are registered or decoded directly from registered state. There is no combinational path from inputs to outputs.
- Single-step latency: the result is visible one cycle after the sampling edge.
- Multi-step command with AMT=N≥1 and EN held high:
  - Steps occur at edges k..k+N-1, where k is the START edge.
  - BUSY is high for N-1 cycles.
  - DONE is high in the cycle after edge k+N-1, coincident with the final Q.
- Each EN=0 cycle in BUSY delays completion by one cycle.
- AMT=0: DONE is high in the cycle after the START edge; BUSY never asserts.

## Structure
- Shared package shreg_pkg holds:
  - mode localparams MODE_HOLD..MODE_CLR
  - state encoding typedef (IDLE, BUSY, DONE)
- Sub-module shreg_step: combinational next-value function (Q, mode, SIL, SIR) -> next Q. It is used for both single-step and BUSY-step paths.
- The top module holds the Q register, cnt register (AW bits), latched mode register, and FSM.

## Test plan
All scenarios use WIDTH=8.
- Reset mid-command: LOAD 8'hA5, then START ROL AMT=5, then RST=1 with EN=0 two edges later -> next cycle Q=8'h00, BUSY=0, DONE=0.
- Enable gating: EN=0, MODE=LOAD, D=8'h3C -> Q holds its previous value. Then EN=1 -> Q=8'h3C one cycle later.
- Single steps from 8'h81:
  - SHL with SIR=1 -> 8'h03, SOUT_L=0.
  - Reload 8'h90, then ASR -> 8'hC8.
  - ROR of 8'h01 -> 8'h80.
- Multi-step: Q=8'h81, START ROL AMT=3, EN=1 -> BUSY high 2 cycles; then DONE high 1 cycle with Q=8'h0C; then IDLE.
- Stall: Q=8'hF0, START SHR AMT=4 SIL=0, EN dropped for 2 cycles after the second step -> final Q=8'h0F. DONE appears 6 cycles after the START edge. Q is unchanged during the stall.
- Degenerate and non-shift START:
  - START with AMT=0 -> DONE next cycle, Q unchanged, BUSY never high.
  - START with MODE=LOAD, D=8'h5A -> Q=8'h5A, no BUSY, no DONE.
